// File: rtl/coin_event_arbiter.sv
// Arbitrates 12 one-cycle event requests into a single held grant (index + valid) for the processor.
// Define ROUND_ROBIN_EN for rotating priority; default build is fixed priority (highest index wins).
module coin_event_arbiter #(
  parameter int unsigned NUM_REQ = 12,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               ack,
  input  logic               err_clr,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic [NUM_REQ-1:0] pending,
  output logic               timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [NUM_REQ-1:0] elig, clr_mask, pending_next;
  logic [ID_W-1:0]    sel_id, grant_id_next;
  logic               any_elig, ack_hit, timeout_hit, issue;
  logic               grant_valid_next, timeout_err_next;

  assign elig        = pending & mask;
  assign any_elig    = |elig;
  assign issue       = (state == IDLE) && any_elig;
  assign ack_hit     = (state == GRANT) && ack;
  assign timeout_hit = (TIMEOUT != 0) && (state == GRANT) && !ack
                       && (cnt == CNT_W'(TIMEOUT - 1));

  // A new req on the bit being cleared survives as a fresh event.
  assign clr_mask     = ack_hit ? (NUM_REQ'(1) << grant_id) : '0;
  assign pending_next = (pending & ~clr_mask) | req;

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] idx;
  logic            found;

  // Descending search starting just below the last serviced line, wrapping 0 -> NUM_REQ-1.
  always_comb begin
    sel_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(rr_ptr) + 2 * NUM_REQ - 1 - k) % NUM_REQ);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        sel_id = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)      rr_ptr <= ID_W'(NUM_REQ - 1);
    else if (issue) rr_ptr <= sel_id;
  end
`else
  // Fixed priority: last match in an ascending scan is the highest index.
  always_comb begin
    sel_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (elig[i]) sel_id = ID_W'(i);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_elig) state_next = GRANT;
      GRANT:   if (ack_hit || timeout_hit) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_valid_next = grant_valid;
    grant_id_next    = grant_id;
    cnt_next         = cnt;
    timeout_err_next = timeout_err;
    if (err_clr) timeout_err_next = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (any_elig) begin
          grant_valid_next = 1'b1;
          grant_id_next    = sel_id;
        end
      end
      GRANT: begin
        if (ack_hit) begin
          grant_valid_next = 1'b0;
        end else if (timeout_hit) begin
          grant_valid_next = 1'b0;
          timeout_err_next = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        grant_valid_next = 1'b0;
        cnt_next         = '0;
      end
      default: begin
        grant_valid_next = 1'b0;
        cnt_next         = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_valid <= 1'b0;
      grant_id    <= '0;
      pending     <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      grant_valid <= grant_valid_next;
      grant_id    <= grant_id_next;
      pending     <= pending_next;
      timeout_err <= timeout_err_next;
      cnt         <= cnt_next;
    end
  end

endmodule
